// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and its pending scoreboard.
// Both the top and the scoreboard import this package so their widths agree.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for issue-stage hazard detection.
// A writeback clears its target; a new long-latency issue sets it, and the set wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_enable,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_address,
    input  logic [NUM_WR-1:0]        clr_enable,
    input  logic [NUM_WR*ADDR_W-1:0] clr_address,
    input  logic [NUM_RD*ADDR_W-1:0] rd_address,
    output logic [NUM_RD-1:0]        rd_pending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clk_enable) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (clr_enable[j]) begin
                    pend_d[clr_address[j*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            // Applied after the clears: a new producer supersedes the retiring one.
            if (sb_set) begin
                pend_d[sb_address] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_pending[i] = pend_q[rd_address[i*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, NUM_WR clocked writes,
// optional same-cycle write forwarding, optional hardwired zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_enable,
    input  logic [NUM_RD*ADDR_W-1:0] r_address,
    output logic [NUM_RD*DATA_W-1:0] o_data,
    output logic [NUM_RD-1:0]        o_pending,
    input  logic [NUM_WR*ADDR_W-1:0] w_address,
    input  logic [NUM_WR*DATA_W-1:0] w_data,
    input  logic [NUM_WR-1:0]        w_enable,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_address
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [NUM_RD-1:0] raw_pending;

    // NOTE: mem_d starts as a copy of mem_q so every path assigns it; no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (clk_enable) begin
            // Later ports overwrite earlier ones, so the highest index wins a conflict.
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_enable[j] &&
                    !((ZERO_REG != 0) && (w_address[j*ADDR_W +: ADDR_W] == '0))) begin
                    mem_d[w_address[j*ADDR_W +: ADDR_W]] = w_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // NOTE: the array is reset because the core relies on all registers reading 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_enable  (clk_enable),
        .sb_set      (sb_set),
        .sb_address  (sb_address),
        .clr_enable  (w_enable),
        .clr_address (w_address),
        .rd_address  (r_address),
        .rd_pending  (raw_pending)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              hit;
        logic [DATA_W-1:0] byp_data;

        assign ra      = r_address[i*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);

        // Forwarding only when the write will actually commit at this edge.
        always_comb begin
            hit      = 1'b0;
            byp_data = '0;
            if ((BYPASS != 0) && clk_enable) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_enable[j] && (w_address[j*ADDR_W +: ADDR_W] == ra)) begin
                        hit      = 1'b1;
                        byp_data = w_data[j*DATA_W +: DATA_W];
                    end
                end
            end
        end

        assign o_data[i*DATA_W +: DATA_W] = is_zero ? '0 : (hit ? byp_data : mem_q[ra]);
        assign o_pending[i]               = !is_zero && !hit && raw_pending[i];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding instance and a non-forwarding
// instance share the same stimulus so both read behaviours are checked side by side.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clk_enable;
    logic [2*AW-1:0] r_address;
    logic [2*DW-1:0] o_data;
    logic [2*DW-1:0] nb_data;
    logic [1:0]      o_pending;
    logic [1:0]      nb_pending;
    logic [2*AW-1:0] w_address;
    logic [2*DW-1:0] w_data;
    logic [1:0]      w_enable;
    logic            sb_set;
    logic [AW-1:0]   sb_address;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W (DW), .ADDR_W (AW), .NUM_RD (2), .NUM_WR (2), .BYPASS (1), .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .r_address  (r_address),
        .o_data     (o_data),
        .o_pending  (o_pending),
        .w_address  (w_address),
        .w_data     (w_data),
        .w_enable   (w_enable),
        .sb_set     (sb_set),
        .sb_address (sb_address)
    );

    regfile_mp #(
        .DATA_W (DW), .ADDR_W (AW), .NUM_RD (2), .NUM_WR (2), .BYPASS (0), .ZERO_REG (1)
    ) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .r_address  (r_address),
        .o_data     (nb_data),
        .o_pending  (nb_pending),
        .w_address  (w_address),
        .w_data     (w_data),
        .w_enable   (w_enable),
        .sb_set     (sb_set),
        .sb_address (sb_address)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_enable = 2'b00;
        sb_set   = 1'b0;
    endtask

    task automatic drive_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_enable[p]          = 1'b1;
        w_address[p*AW +: AW] = a;
        w_data[p*DW +: DW]   = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        r_address[p*AW +: AW] = a;
    endtask

    task automatic mark(input logic [AW-1:0] a);
        sb_set     = 1'b1;
        sb_address = a;
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_enable = 1'b1;
        r_address  = '0;
        w_address  = '0;
        w_data     = '0;
        w_enable   = '0;
        sb_set     = 1'b0;
        sb_address = '0;
        #2;
        rst_n = 1'b1;
        tick();

        // Reset: preload r5/r6 and mark r6, then pulse reset between edges.
        drive_wr(0, 5'd5, 32'h0000_AAAA);
        drive_wr(1, 5'd6, 32'h0000_BBBB);
        mark(5'd6);
        set_rd(0, 5'd5);
        set_rd(1, 5'd6);
        tick();
        idle_inputs();
        #1;
        check("preload_r5", o_data[31:0], 32'h0000_AAAA);
        check("preload_r6_pend", {31'd0, o_pending[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_data0", o_data[31:0], 32'h0);
        check("rst_data1", o_data[63:32], 32'h0);
        check("rst_pending", {30'd0, o_pending}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write / read, and the hardwired zero register.
        drive_wr(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        set_rd(0, 5'd5);
        #1;
        check("wr_r5", o_data[31:0], 32'hDEAD_BEEF);
        check("wr_r5_nb", nb_data[31:0], 32'hDEAD_BEEF);
        drive_wr(0, 5'd0, 32'h0000_1234);
        set_rd(1, 5'd0);
        #1;
        check("r0_bypass", o_data[63:32], 32'h0);
        tick();
        idle_inputs();
        #1;
        check("r0_after", o_data[63:32], 32'h0);
        check("r0_after_nb", nb_data[63:32], 32'h0);

        // Write-port conflict: highest index wins in the array and the bypass.
        drive_wr(0, 5'd7, 32'h0000_0011);
        drive_wr(1, 5'd7, 32'h0000_0022);
        set_rd(0, 5'd7);
        #1;
        check("conflict_bypass", o_data[31:0], 32'h0000_0022);
        check("conflict_nb_old", nb_data[31:0], 32'h0);
        tick();
        idle_inputs();
        #1;
        check("conflict_r7", o_data[31:0], 32'h0000_0022);
        check("conflict_r7_nb", nb_data[31:0], 32'h0000_0022);

        // Bypass versus raw array read.
        drive_wr(0, 5'd9, 32'h0000_0005);
        tick();
        drive_wr(0, 5'd9, 32'h0000_000A);
        set_rd(0, 5'd9);
        #1;
        check("bypass_new", o_data[31:0], 32'h0000_000A);
        check("nobypass_old", nb_data[31:0], 32'h0000_0005);
        tick();
        idle_inputs();
        #1;
        check("after_edge_r9", o_data[31:0], 32'h0000_000A);
        check("after_edge_r9_nb", nb_data[31:0], 32'h0000_000A);

        // Scoreboard set, clear by writeback, and set-beats-clear.
        mark(5'd3);
        set_rd(1, 5'd3);
        #1;
        check("sb_before_edge", {31'd0, o_pending[1]}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check("sb_set_r3", {31'd0, o_pending[1]}, 32'd1);
        check("sb_set_r3_nb", {31'd0, nb_pending[1]}, 32'd1);
        drive_wr(1, 5'd3, 32'h0000_0033);
        #1;
        check("sb_wb_mask", {31'd0, o_pending[1]}, 32'd0);
        check("sb_wb_data", o_data[63:32], 32'h0000_0033);
        check("sb_wb_nb_raw", {31'd0, nb_pending[1]}, 32'd1);
        tick();
        idle_inputs();
        #1;
        check("sb_cleared", {31'd0, o_pending[1]}, 32'd0);
        check("sb_cleared_nb", {31'd0, nb_pending[1]}, 32'd0);
        mark(5'd3);
        drive_wr(0, 5'd3, 32'h0000_0044);
        tick();
        idle_inputs();
        #1;
        check("sb_set_wins", {31'd0, o_pending[1]}, 32'd1);
        check("sb_set_wins_data", o_data[63:32], 32'h0000_0044);
        mark(5'd0);
        set_rd(0, 5'd0);
        tick();
        idle_inputs();
        #1;
        check("sb_r0_ignored", {31'd0, o_pending[0]}, 32'd0);

        // Stall: writes and sb_set held for three edges with clk_enable low.
        clk_enable = 1'b0;
        drive_wr(0, 5'd3, 32'h0000_0099);
        drive_wr(1, 5'd10, 32'h0000_0077);
        mark(5'd11);
        set_rd(0, 5'd3);
        set_rd(1, 5'd10);
        #1;
        check("stall_no_bypass", o_data[31:0], 32'h0000_0044);
        check("stall_pend_kept", {31'd0, o_pending[0]}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_r3", o_data[31:0], 32'h0000_0044);
            check("stall_r10", o_data[63:32], 32'h0);
            check("stall_r3_pend", {31'd0, o_pending[0]}, 32'd1);
        end
        idle_inputs();
        clk_enable = 1'b1;
        set_rd(1, 5'd11);
        #1;
        check("stall_sb_frozen", {31'd0, o_pending[1]}, 32'd0);
        check("stall_r3_final", o_data[31:0], 32'h0000_0044);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
